// File: rtl/traffic_light_controller_n_if.sv
// Phase-side signals of the N-phase traffic light controller: sensor/flash requests in,
// per-phase colors and status out.
interface traffic_light_controller_n_if #(
  parameter int NPH = 5
);
  localparam int PW = $clog2(NPH);

  logic [NPH-1:0]   sensor;
  logic             flash;
  logic [2*NPH-1:0] lights;
  logic [PW-1:0]    active_phase;
  logic             green_on;

  modport master (
    output sensor, flash,
    input  lights, active_phase, green_on
  );

  modport slave (
    input  sensor, flash,
    output lights, active_phase, green_on
  );
endinterface

// File: rtl/traffic_light_controller_n.sv
// N-phase round-robin traffic light controller: Moore FSM with vacancy/max-green timing,
// yellow and all-red clearance, and a flashing mode on the last served phase.
package light_package;
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } colors;
endpackage

module traffic_light_controller_n
  import light_package::*;
#(
  parameter int NPH      = 5,
  parameter int YEL_CYC  = 2,
  parameter int ARED_CYC = 1,
  parameter int VAC_CYC  = 4,
  parameter int MAX_CYC  = 9,
  parameter int FL_CYC   = 1
) (
  input logic                       clk,
  input logic                       reset,
  traffic_light_controller_n_if.slave bus
);

  localparam int PW   = $clog2(NPH);
  localparam int M_A  = (YEL_CYC > ARED_CYC) ? YEL_CYC : ARED_CYC;
  localparam int M_B  = (VAC_CYC > MAX_CYC) ? VAC_CYC : MAX_CYC;
  localparam int M_C  = (M_A > M_B) ? M_A : M_B;
  localparam int CMAX = (M_C > FL_CYC) ? M_C : FL_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] YEL_LAST  = CW'(YEL_CYC - 1);
  localparam logic [CW-1:0] ARED_LAST = CW'(ARED_CYC - 1);
  localparam logic [CW-1:0] VAC_LAST  = CW'(VAC_CYC - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0] FL_LAST   = CW'(FL_CYC - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(NPH - 1);

  typedef enum logic [1:0] {
    S_ALLRED = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_FLASH  = 2'b11
  } state_t;

  state_t          r_state,   w_state;
  logic [PW-1:0]   r_phase,   w_phase;
  logic [CW-1:0]   r_tmr,     w_tmr;
  logic [CW-1:0]   r_max_ctr, w_max_ctr;
  logic [CW-1:0]   r_vac_ctr, w_vac_ctr;
  logic            r_fl_on,   w_fl_on;

  logic            w_grant_vld;
  logic [PW-1:0]   w_grant;
  logic            w_own;
  logic            w_others;
  colors           w_col;
  logic [2*NPH-1:0] w_lights;
  logic [NPH-1:0]  w_nonred;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NPH) s = s - NPH;
    return PW'(s);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Scan farthest-to-nearest so the nearest requester after r_phase wins; r_phase itself is last.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_phase;
    for (int k = NPH; k >= 1; k--) begin
      if (bus.sensor[wrap_add(r_phase, k)]) begin
        w_grant_vld = 1'b1;
        w_grant     = wrap_add(r_phase, k);
      end
    end
  end

  always_comb begin
    w_own    = bus.sensor[r_phase];
    w_others = |(bus.sensor & ~(NPH'(1) << r_phase));
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state   = r_state;
    w_phase   = r_phase;
    w_tmr     = r_tmr;
    w_max_ctr = r_max_ctr;
    w_vac_ctr = r_vac_ctr;
    w_fl_on   = r_fl_on;
    case (r_state)
      S_ALLRED: begin
        if (r_tmr != '0) begin
          w_tmr = r_tmr - 1'b1;
        end else if (bus.flash) begin
          w_state = S_FLASH;
          w_tmr   = FL_LAST;
          w_fl_on = 1'b1;
        end else if (w_grant_vld) begin
          w_state   = S_GREEN;
          w_phase   = w_grant;
          w_max_ctr = '0;
          w_vac_ctr = '0;
        end
      end
      S_GREEN: begin
        if ((w_others && (r_max_ctr == MAX_LAST)) ||
            (!w_own && (r_vac_ctr == VAC_LAST)) || bus.flash) begin
          w_state = S_YELLOW;
          w_tmr   = YEL_LAST;
        end else begin
          w_max_ctr = w_others ? sat_inc(r_max_ctr) : '0;
          w_vac_ctr = !w_own   ? sat_inc(r_vac_ctr) : '0;
        end
      end
      S_YELLOW: begin
        if (r_tmr != '0) begin
          w_tmr = r_tmr - 1'b1;
        end else begin
          w_state = S_ALLRED;
          w_tmr   = ARED_LAST;
        end
      end
      S_FLASH: begin
        if (!bus.flash) begin
          w_state = S_ALLRED;
          w_tmr   = ARED_LAST;
          w_fl_on = 1'b0;
        end else if (r_tmr != '0) begin
          w_tmr = r_tmr - 1'b1;
        end else begin
          w_tmr   = FL_LAST;
          w_fl_on = !r_fl_on;
        end
      end
      default: begin
        w_state = S_ALLRED;
        w_tmr   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_ALLRED;
      r_phase   <= LAST_PH;
      r_tmr     <= '0;
      r_max_ctr <= '0;
      r_vac_ctr <= '0;
      r_fl_on   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state   <= w_state;
      r_phase   <= w_phase;
      r_tmr     <= w_tmr;
      r_max_ctr <= w_max_ctr;
      r_vac_ctr <= w_vac_ctr;
      r_fl_on   <= w_fl_on;
    end
  end

  // Outputs decode only from registers, so reset turns every light red without a clock.
  always_comb begin
    case (r_state)
      S_GREEN:  w_col = GREEN;
      S_YELLOW: w_col = YELLOW;
      S_FLASH:  w_col = r_fl_on ? YELLOW : RED;
      default:  w_col = RED;
    endcase
    w_lights = '0;
    w_nonred = '0;
    for (int p = 0; p < NPH; p++) begin
      w_lights[2*p +: 2] = (PW'(p) == r_phase) ? w_col : RED;
      w_nonred[p]        = (w_lights[2*p +: 2] != RED);
    end
  end

  assign bus.lights       = w_lights;
  assign bus.active_phase = r_phase;
  assign bus.green_on     = (r_state == S_GREEN);

  a_one_nonred: assert property (@(posedge clk) disable iff (!reset) $onehot0(w_nonred));

endmodule

// File: doc/traffic_light_controller_n.md
TRAFFIC_LIGHT_CONTROLLER_N -- requirements
Module: traffic_light_controller_n

Interface
REQ-001 SHALL have parameter NPH, default 5: number of mutually exclusive phases, legal range 2..16.
REQ-002 SHALL have parameter YEL_CYC, default 2: yellow duration in cycles, minimum 1.
REQ-003 SHALL have parameter ARED_CYC, default 1: all-red duration in cycles, minimum 1.
REQ-004 SHALL have parameter VAC_CYC, default 4: green hold after own traffic leaves, in cycles, minimum 1.
REQ-005 SHALL have parameter MAX_CYC, default 9: green limit while other phases wait, in cycles, minimum 1.
REQ-006 SHALL have parameter FL_CYC, default 1: flash half-period in cycles, minimum 1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port sensor, input, NPH bits: bit p high means phase p requests service.
REQ-010 SHALL have port flash, input, 1 bit: request for flashing mode.
REQ-011 SHALL have port lights, output, 2*NPH bits: field [2p+1:2p] carries phase p color as light_package colors value (red, yellow, green).
REQ-012 SHALL have port active_phase, output, $clog2(NPH) bits: phase currently green/yellow, else last phase served.
REQ-013 SHALL have port green_on, output, 1 bit: high when some phase is green.

Function
REQ-014 SHALL implement a Moore machine with states ALLRED, GREEN, YELLOW, FLASH; outputs decode only from registered state, phase and counters.
REQ-015 SHALL drive at most one phase non-red at any cycle; all phases other than active_phase SHALL be red.
REQ-016 SHALL, in ALLRED, count ARED_CYC cycles; after expiry it SHALL arbitrate on every edge and hold ALLRED (idle) while no sensor bit is set and flash=0.
REQ-017 SHALL arbitrate round-robin: search phases active_phase+1, +2, ... modulo NPH, active_phase last; grant the first requesting phase; grant takes effect on the same edge (GREEN visible the following cycle).
REQ-018 SHALL, in ALLRED after expiry with flash=1, enter FLASH in preference to any grant.
REQ-019 SHALL, on entering GREEN, clear max_ctr and vac_ctr.
REQ-020 SHALL, in GREEN, increment max_ctr on each edge where any other sensor bit is high, else clear it.
REQ-021 SHALL, in GREEN, increment vac_ctr on each edge where own sensor bit is low, else clear it.
REQ-022 SHALL leave GREEN for YELLOW on the edge where (others requesting and max_ctr==MAX_CYC-1) or (own low and vac_ctr==VAC_CYC-1) or flash=1.
REQ-023 SHALL hold YELLOW exactly YEL_CYC cycles, then enter ALLRED with timer reloaded; sensors and flash are ignored in YELLOW.
REQ-024 SHALL, in FLASH, show active_phase only alternating yellow/red every FL_CYC cycles starting yellow; other phases red; green_on=0.
REQ-025 SHALL leave FLASH for ALLRED (timer reloaded) on the edge where flash=0.
REQ-026 SHALL size counters to hold max(YEL_CYC, ARED_CYC, VAC_CYC, MAX_CYC, FL_CYC)-1 without wrap; counters SHALL saturate, never wrap.
REQ-027 SHALL treat unreachable state encodings as ALLRED with timer expired.

Reset
REQ-028 SHALL, while reset=0, force state ALLRED with timer expired, active_phase=NPH-1, counters 0, all lights red, green_on=0, independent of clk.
REQ-029 SHALL, on reset assertion mid-GREEN/YELLOW/FLASH, drop all lights to red immediately (asynchronously).
REQ-030 SHALL resume arbitration on the first rising clk edge after reset returns high; the first search starts at phase 0.

Verification (defaults NPH=5, YEL=2, ARED=1, VAC=4, MAX=9, FL=1)
REQ-031 SHALL cover: reset released, sensor=5'b00100 -> after first edge phase 2 green, active_phase=2, green_on=1.
REQ-032 SHALL cover: phase 2 green, sensor drops to 0 -> 4 more green cycles, 2 yellow, 1 all-red, then idle all red.
REQ-033 SHALL cover: phase 0 green, sensor=5'b01001 held -> green exactly 9 cycles, yellow 2, all-red 1, then phase 3 green.
REQ-034 SHALL cover: phase 4 ends, sensor=5'b01010 -> grant phase 1 (wrap); phase 1 ends with same sensors -> grant phase 3.
REQ-035 SHALL cover: flash=1 mid-green of phase 1 -> yellow next cycle, 2 yellow, 1 all-red, then phase 1 alternating yellow/red each cycle; flash=0 -> 1 all-red, arbitration resumes.
REQ-036 SHALL cover: reset low during yellow -> all red same cycle; release with sensor=5'b11111 -> phase 0 green after first edge.
